// File: rtl/conv_filter_scheduler.sv
// conv_filter_scheduler: walks a layer of K filters through P parallel
// single-filter engines, one group of P filters per pass. Each pass runs
// from an engine reset to a capture strobe. The pass ends when the engines
// report done or when a per-pass watchdog expires.
module conv_filter_scheduler #(
   parameter int K           = 6,
   parameter int P           = 2,
   parameter int PASS_CYCLES = 3,
   parameter int SET_W       = 8,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic             eng_done,
   output logic             eng_reset,
   output logic [SET_W-1:0] filter_set,
   output logic [P-1:0]     eng_valid,
   output logic             out_we,
   output logic             busy,
   output logic             done,
   output logic             timeout
);

   localparam int unsigned NSETS = (K + P - 1) / P;
   localparam int unsigned REM   = K % P;
   localparam logic [SET_W-1:0] LAST_SET = SET_W'(NSETS - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PASS_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, RST, RUN, CAPTURE, FINISH} state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic             last_set;
   logic             pass_end;

   assign last_set = (filter_set == LAST_SET);
   assign pass_end = eng_done || (cnt == CNT_LAST);

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic. Abort wins over pass completion in the same cycle.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (start) state_nxt = RST;
         RST:     state_nxt = abort ? IDLE : RUN;
         RUN: begin
            if (abort)         state_nxt = IDLE;
            else if (pass_end) state_nxt = CAPTURE;
         end
         CAPTURE: begin
            if (abort)         state_nxt = IDLE;
            else if (last_set) state_nxt = FINISH;
            else               state_nxt = RST;
         end
         FINISH:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Filter-set index, pass counter and sticky watchdog flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         filter_set <= '0;
         cnt        <= '0;
         timeout    <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  filter_set <= '0;
                  timeout    <= 1'b0;
               end
            end
            RST: cnt <= '0;
            RUN: begin
               cnt <= cnt + 1'b1;
               // Only a pass that actually ends on the watchdog counts.
               if (!abort && !eng_done && (cnt == CNT_LAST)) timeout <= 1'b1;
            end
            CAPTURE: begin
               if (!abort && !last_set) filter_set <= filter_set + 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Control outputs decoded from state only.
   always_comb begin
      eng_reset = (state == IDLE) || (state == RST) || (state == FINISH);
      out_we    = (state == CAPTURE);
      busy      = (state != IDLE);
      done      = (state == FINISH);
   end

   // Engine-valid mask; a partial final group enables only the low REM engines.
   always_comb begin
      eng_valid = '1;
      for (int unsigned i = 0; i < P; i++) begin
         if ((REM != 0) && last_set && (i >= REM)) eng_valid[i] = 1'b0;
      end
   end

endmodule

// File: tb/tb_conv_filter_scheduler.sv
// Directed bench for conv_filter_scheduler: K=5 and K=6 instances run in
// lockstep (both have three filter sets); a K=2 instance covers the
// single-set watchdog layer.
module tb_conv_filter_scheduler;

   logic       clk = 1'b0;
   logic       reset, start, abort, eng_done;
   logic       start2, eng_done2;

   logic       er5, we5, busy5, done5, to5;
   logic [7:0] fs5;
   logic [1:0] ev5;
   logic       er6, we6, busy6, done6, to6;
   logic [7:0] fs6;
   logic [1:0] ev6;
   logic       er2, we2, busy2, done2, to2;
   logic [7:0] fs2;
   logic [1:0] ev2;

   int errors = 0;
   int checks = 0;
   int nwe    = 0;
   int ndone  = 0;

   always #5 clk = ~clk;

   conv_filter_scheduler #(.K(5), .P(2), .PASS_CYCLES(3), .SET_W(8), .CNT_W(16)) u_dut5 (
      .clk(clk), .reset(reset), .start(start), .abort(abort), .eng_done(eng_done),
      .eng_reset(er5), .filter_set(fs5), .eng_valid(ev5), .out_we(we5),
      .busy(busy5), .done(done5), .timeout(to5));

   conv_filter_scheduler #(.K(6), .P(2), .PASS_CYCLES(3), .SET_W(8), .CNT_W(16)) u_dut6 (
      .clk(clk), .reset(reset), .start(start), .abort(abort), .eng_done(eng_done),
      .eng_reset(er6), .filter_set(fs6), .eng_valid(ev6), .out_we(we6),
      .busy(busy6), .done(done6), .timeout(to6));

   conv_filter_scheduler #(.K(2), .P(2), .PASS_CYCLES(3), .SET_W(8), .CNT_W(16)) u_dut2 (
      .clk(clk), .reset(reset), .start(start2), .abort(abort), .eng_done(eng_done2),
      .eng_reset(er2), .filter_set(fs2), .eng_valid(ev2), .out_we(we2),
      .busy(busy2), .done(done2), .timeout(to2));

   // Pulse counters for the K=5 instance.
   always @(posedge clk) begin
      if (we5)   nwe   <= nwe + 1;
      if (done5) ndone <= ndone + 1;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      reset = 1'b0; start = 1'b0; abort = 1'b0; eng_done = 1'b0;
      start2 = 1'b0; eng_done2 = 1'b0;
      #1 reset = 1'b1;
      #2;
      chk("rst_fs",      32'(fs5),   0);
      chk("rst_er",      32'(er5),   1);
      chk("rst_we",      32'(we5),   0);
      chk("rst_busy",    32'(busy5), 0);
      chk("rst_done",    32'(done5), 0);
      chk("rst_timeout", 32'(to5),   0);
      tick; tick;
      reset = 1'b0;
      tick;
      chk("idle_er", 32'(er5), 1);

      // Layer A: eng_done one cycle after each RUN entry.
      start = 1'b1;
      tick;
      start = 1'b0;
      for (int s = 0; s < 3; s++) begin
         chk("A_rst_er",   32'(er5),   1);
         chk("A_rst_busy", 32'(busy5), 1);
         chk("A_rst_fs",   32'(fs5),   32'(s));
         chk("A_rst_we",   32'(we5),   0);
         tick;
         chk("A_run_er", 32'(er5), 0);
         eng_done = 1'b1;
         tick;
         eng_done = 1'b0;
         chk("A_cap_we",  32'(we5), 1);
         chk("A_cap_fs",  32'(fs5), 32'(s));
         chk("A_cap_er",  32'(er5), 0);
         chk("A_cap_ev5", 32'(ev5), (s < 2) ? 32'h3 : 32'h1);
         chk("A_cap_ev6", 32'(ev6), 32'h3);
         chk("A_cap_fs6", 32'(fs6), 32'(s));
         tick;
      end
      chk("A_fin_done",  32'(done5), 1);
      chk("A_fin_done6", 32'(done6), 1);
      chk("A_fin_er",    32'(er5),   1);
      chk("A_fin_fs",    32'(fs5),   2);
      chk("A_fin_to",    32'(to5),   0);
      tick;
      chk("A_idle_done", 32'(done5), 0);
      chk("A_idle_busy", 32'(busy5), 0);
      chk("A_idle_fs",   32'(fs5),   2);
      chk("A_nwe",       32'(nwe),   3);
      chk("A_ndone",     32'(ndone), 1);

      // Layer B: watchdog ends the first pass; later passes finish normally.
      start = 1'b1;
      tick;
      start = 1'b0;
      tick;
      chk("B_run0_we", 32'(we5), 0);
      tick;
      chk("B_run1_we", 32'(we5), 0);
      tick;
      chk("B_run2_we", 32'(we5), 0);
      tick;
      chk("B_cap_we", 32'(we5), 1);
      chk("B_cap_to", 32'(to5), 1);
      eng_done = 1'b1;
      tick; tick; tick; tick; tick; tick; tick;
      chk("B_fin_done", 32'(done5), 1);
      chk("B_fin_to",   32'(to5),   1);
      eng_done = 1'b0;
      tick;
      chk("B_idle_to", 32'(to5), 1);

      // Layer C: eng_done coincides with counter limit, then abort in RUN of set 1.
      start = 1'b1;
      tick;
      start = 1'b0;
      chk("C_to_clear", 32'(to5), 0);
      tick; tick; tick;
      eng_done = 1'b1;
      tick;
      eng_done = 1'b0;
      chk("C_cap_we", 32'(we5), 1);
      chk("C_cap_to", 32'(to5), 0);
      tick;
      chk("C_rst1_fs", 32'(fs5), 1);
      tick;
      abort = 1'b1; eng_done = 1'b1;
      tick;
      abort = 1'b0; eng_done = 1'b0;
      chk("C_abort_busy", 32'(busy5), 0);
      chk("C_abort_we",   32'(we5),   0);
      chk("C_abort_er",   32'(er5),   1);
      tick; tick; tick;
      chk("C_nwe",   32'(nwe),   7);
      chk("C_ndone", 32'(ndone), 2);
      abort = 1'b1;
      tick;
      abort = 1'b0;
      chk("C_idle_abort_busy", 32'(busy5), 0);

      // Layer D: restart at set 0, then reset during CAPTURE of set 1.
      start = 1'b1;
      tick;
      start = 1'b0;
      chk("D_restart_fs", 32'(fs5), 0);
      eng_done = 1'b1;
      tick; tick; tick; tick; tick;
      chk("D_cap1_we", 32'(we5), 1);
      chk("D_cap1_fs", 32'(fs5), 1);
      reset = 1'b1;
      #1;
      chk("D_reset_we",   32'(we5),   0);
      chk("D_reset_fs",   32'(fs5),   0);
      chk("D_reset_busy", 32'(busy5), 0);
      chk("D_reset_er",   32'(er5),   1);
      tick;
      reset = 1'b0; eng_done = 1'b0;
      tick; tick; tick;
      chk("D_nwe",   32'(nwe),   8);
      chk("D_ndone", 32'(ndone), 2);

      // Layer E: start toggled throughout a busy layer.
      start = 1'b1; eng_done = 1'b1;
      tick;
      for (int i = 1; i <= 8; i++) begin
         start = (i % 2 == 1);
         tick;
      end
      start = 1'b0;
      tick;
      chk("E_fin_done", 32'(done5), 1);
      tick; tick; tick;
      eng_done = 1'b0;
      chk("E_idle_busy", 32'(busy5), 0);
      chk("E_ndone",     32'(ndone), 3);
      chk("E_nwe",       32'(nwe),   11);

      // Layer F: K=2 single set, eng_done held low.
      start2 = 1'b1;
      tick;
      start2 = 1'b0;
      chk("F_rst_busy", 32'(busy2), 1);
      chk("F_ev",       32'(ev2),   32'h3);
      tick; tick; tick;
      chk("F_run2_we", 32'(we2), 0);
      tick;
      chk("F_cap_we", 32'(we2), 1);
      chk("F_cap_to", 32'(to2), 1);
      chk("F_cap_fs", 32'(fs2), 0);
      tick;
      chk("F_fin_done", 32'(done2), 1);
      tick;
      chk("F_idle_done", 32'(done2), 0);
      chk("F_idle_to",   32'(to2),   1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/conv_filter_scheduler.md
CONV_FILTER_SCHEDULER -- requirements
Module: conv_filter_scheduler

Interface
REQ-001 SHALL have parameter K, default 6, meaning total number of filters in the layer (K >= 1).
REQ-002 SHALL have parameter P, default 2, meaning number of parallel single-filter convolution engines (P >= 1).
REQ-003 SHALL have parameter PASS_CYCLES, default 3 (simulation scale; production 1000+), meaning watchdog limit in cycles for one engine pass (>= 2).
REQ-004 SHALL have parameter SET_W, default 8, meaning filter-set counter width, at least clog2(ceil(K/P)).
REQ-005 SHALL have parameter CNT_W, default 16, meaning pass-cycle counter width, at least clog2(PASS_CYCLES+1).
REQ-006 Port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-007 Port reset, input, 1, asynchronous and active-high.
REQ-008 Port start, input, 1, requests processing of one layer; sampled only in IDLE.
REQ-009 Port abort, input, 1, synchronous cancel of the current layer.
REQ-010 Port eng_done, input, 1, engines report that current pass outputs are valid.
REQ-011 Port eng_reset, output, 1, reset to the convolution engines.
REQ-012 Port filter_set, output, SET_W, index of the current filter group; engines consume filters [filter_set*P .. filter_set*P+P-1].
REQ-013 Port eng_valid, output, P, bit i set when engine i holds a real filter in the current set.
REQ-014 Port out_we, output, 1, one-cycle write strobe; capture engine outputs into output slot filter_set.
REQ-015 Port busy, output, 1, high in every state except IDLE.
REQ-016 Port done, output, 1, one-cycle pulse at layer completion.
REQ-017 Port timeout, output, 1, sticky flag set when any pass ended by watchdog; cleared on the next accepted start.

Function
REQ-018 SHALL implement states IDLE, RST, RUN, CAPTURE, FINISH.
REQ-019 NSETS = ceil(K/P); filter_set SHALL range 0..NSETS-1.
REQ-020 IDLE: eng_reset=1, out_we=0, busy=0; start=1 -> RST with filter_set=0, timeout cleared.
REQ-021 RST: eng_reset=1 for exactly one cycle, pass counter cleared -> RUN.
REQ-022 RUN: eng_reset=0; counter increments each cycle; eng_done=1 or counter==PASS_CYCLES-1 -> CAPTURE.
REQ-023 Pass ended by counter with eng_done=0 SHALL set timeout; eng_done and counter limit in the same cycle SHALL NOT set timeout.
REQ-024 CAPTURE: out_we=1 for exactly one cycle, eng_reset=0, filter_set stable; if filter_set==NSETS-1 -> FINISH, else filter_set+1 -> RST.
REQ-025 FINISH: done=1 for one cycle, eng_reset=1 -> IDLE; filter_set holds last value until the next start.
REQ-026 eng_valid SHALL be all ones except in the final set when K mod P != 0, where only the low (K mod P) bits are set.
REQ-027 Minimum latency start -> done = NSETS*(RUN cycles + 2) + 1 cycles.
REQ-028 start while busy SHALL be ignored; no queued request.
REQ-029 abort in RST, RUN, or CAPTURE -> IDLE next cycle; no out_we, no done; abort takes priority over eng_done and counter expiry in the same cycle; abort in IDLE or FINISH has no effect.
REQ-030 eng_done outside RUN SHALL be ignored.
REQ-031 All outputs SHALL be registered or decoded from state only; no combinational input-to-output path.

Reset
REQ-032 reset=1 SHALL immediately force IDLE, filter_set=0, counter=0, eng_reset=1, out_we=0, busy=0, done=0, timeout=0.
REQ-033 Reset asserted mid-layer SHALL discard progress; no done and no out_we afterward until a new start.

Verification
REQ-034 K=6,P=2: start, eng_done 1 cycle after each RUN entry -> out_we pulses with filter_set 0,1,2, single done pulse, timeout=0.
REQ-035 K=5,P=2: full layer -> eng_valid=2'b11 for sets 0,1 and 2'b01 for set 2; 3 out_we pulses.
REQ-036 K=2,P=2,PASS_CYCLES=3, eng_done held 0 -> CAPTURE after 3 RUN cycles, timeout=1, done still pulses.
REQ-037 abort during RUN of set 1 -> IDLE next cycle, no further out_we, no done; new start restarts at set 0.
REQ-038 reset asserted during CAPTURE of set 1 -> out_we drops immediately, filter_set=0, busy=0, eng_reset=1.
REQ-039 start pulsed repeatedly while busy -> exactly one done per accepted start.
